// File: rtl/vp_pkg.sv
// ============================================================================
// Module   : vp_pkg
// Purpose  : Shared types and path-index constants for the vp mode scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vp_pkg;

  localparam int SEL_W = 3;

  localparam int PATH_BYPASS   = 0;
  localparam int PATH_YCBCR    = 1;
  localparam int PATH_BIN      = 2;
  localparam int PATH_CENTROID = 3;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vp_sw_debounce.sv
// ============================================================================
// Module   : vp_sw_debounce
// Purpose  : Two-flop switch synchronizer followed by a stability counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vp_sw_debounce #(
  parameter int SEL_W           = 3,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sw_i,
  output logic [SEL_W-1:0] sw_stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SEL_W-1:0] meta_q;
  logic [SEL_W-1:0] sync_q;
  logic [SEL_W-1:0] prev_q;
  logic [SEL_W-1:0] stable_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      // Counter holds at its terminal value so a long-stable input keeps loading.
      if (sync_q != prev_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sw_stable_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/vp_mode_sched.sv
// ============================================================================
// Module   : vp_mode_sched
// Purpose  : Frame-synchronous path-select scheduler with post-switch blanking.
//            Optional macro VP_MODE_SCHED_TIMEOUT_EN commits without vsync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vp_mode_sched #(
  parameter int SEL_W           = vp_pkg::SEL_W,
  parameter int NUM_PATHS       = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int BLANK_FRAMES    = 2,
  parameter int VSYNC_POL       = 1,
  parameter int TIMEOUT_CYCLES  = 4000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sw_in,
  input  logic             v_sync_in,
  output logic [SEL_W-1:0] sel_out,
  output logic             blank,
  output logic             centroid_clr,
  output logic             busy,
  output logic             sel_invalid,
  output logic [15:0]      frame_cnt
);

  import vp_pkg::*;

  localparam logic VS_ACT = (VSYNC_POL != 0);
  localparam int   BW     = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;

  logic [SEL_W-1:0] sw_stable;
  logic             sw_valid;
  logic             fs;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             clr_q, clr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             vs_q;
  logic             busy_q;
  logic             inval_q;
  logic [15:0]      fcnt_q;

`ifdef VP_MODE_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  vp_sw_debounce #(
    .SEL_W           (SEL_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_i        (sw_in),
    .sw_stable_o (sw_stable)
  );

  assign sw_valid = ({1'b0, sw_stable} < (SEL_W + 1)'(NUM_PATHS));
  assign fs       = (v_sync_in == VS_ACT) && (vs_q != VS_ACT);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    blank_d  = blank_q;
    clr_d    = 1'b0;
    bcnt_d   = bcnt_q;
`ifdef VP_MODE_SCHED_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      ACTIVE: begin
        if (sw_valid && (sw_stable != sel_q)) begin
          target_d = sw_stable;
          state_d  = PENDING;
        end
      end
      PENDING: begin
`ifdef VP_MODE_SCHED_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
`endif
        // A request cancelled before the frame start leaves no trace.
        if (sw_stable == sel_q) begin
          state_d = ACTIVE;
        end else if (fs) begin
          sel_d = target_q;
          clr_d = 1'b1;
          if (BLANK_FRAMES == 0) begin
            state_d = ACTIVE;
          end else begin
            blank_d = 1'b1;
            bcnt_d  = BW'(BLANK_FRAMES);
            state_d = BLANK;
          end
`ifdef VP_MODE_SCHED_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          sel_d   = target_q;
          clr_d   = 1'b1;
          state_d = ACTIVE;
`endif
        end else if (sw_valid) begin
          target_d = sw_stable;
        end
      end
      BLANK: begin
        if (fs) begin
          if (bcnt_q == BW'(1)) begin
            blank_d = 1'b0;
            state_d = ACTIVE;
          end else begin
            bcnt_d = bcnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ACTIVE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACTIVE;
      target_q <= '0;
      sel_q    <= SEL_W'(PATH_BYPASS);
      blank_q  <= 1'b0;
      clr_q    <= 1'b0;
      bcnt_q   <= '0;
      vs_q     <= ~VS_ACT;
      busy_q   <= 1'b0;
      inval_q  <= 1'b0;
      fcnt_q   <= '0;
`ifdef VP_MODE_SCHED_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
      clr_q    <= clr_d;
      bcnt_q   <= bcnt_d;
      vs_q     <= v_sync_in;
      busy_q   <= (state_d != ACTIVE);
      inval_q  <= ~sw_valid;
      if (fs) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
`ifdef VP_MODE_SCHED_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign sel_out      = sel_q;
  assign blank        = blank_q;
  assign centroid_clr = clr_q;
  assign busy         = busy_q;
  assign sel_invalid  = inval_q;
  assign frame_cnt    = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vp_mode_sched.sv
// ============================================================================
// Module   : tb_vp_mode_sched
// Purpose  : Directed self-checking bench for vp_mode_sched; the timeout case
//            runs only when VP_MODE_SCHED_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vp_mode_sched;

  localparam int SEL_W = 3;
  localparam int FRAME = 100;
  localparam int VS_HI = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SEL_W-1:0] sw_in = '0;
  logic             v_sync_in = 1'b0;
  logic [SEL_W-1:0] sel_out;
  logic             blank;
  logic             centroid_clr;
  logic             busy;
  logic             sel_invalid;
  logic [15:0]      frame_cnt;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ph     = FRAME - 1;
  int   rises  = 0;
  int   base   = 0;
  logic vs_en  = 1'b0;

  vp_mode_sched #(
    .SEL_W           (SEL_W),
    .NUM_PATHS       (4),
    .DEBOUNCE_CYCLES (4),
    .BLANK_FRAMES    (2),
    .VSYNC_POL       (1),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_in        (sw_in),
    .v_sync_in    (v_sync_in),
    .sel_out      (sel_out),
    .blank        (blank),
    .centroid_clr (centroid_clr),
    .busy         (busy),
    .sel_invalid  (sel_invalid),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Frame generator: 100-clock frames, vsync high for the first 5 clocks.
  always @(negedge clk) begin
    if (vs_en) ph = (ph >= FRAME - 1) ? 0 : ph + 1;
    else       ph = FRAME - 1;
    if (vs_en && ph < VS_HI) begin
      if (!v_sync_in) rises = rises + 1;
      v_sync_in = 1'b1;
    end else begin
      v_sync_in = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the clock edge that samples a new vsync rising edge.
  task automatic wait_fs();
    int  r0;
    bit  hit;
    r0  = rises;
    hit = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk);
      if (rises != r0) begin
        hit = 1'b1;
        break;
      end
    end
    #1;
    if (!hit) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;

    // Reset state
    tick(3);
    chk("rst_sel", sel_out, 0);
    chk("rst_blank", blank, 0);
    chk("rst_clr", centroid_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inval", sel_invalid, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;
    base  = rises;
    vs_en = 1'b1;
    wait_fs();

    // 1: switch to path 3, commit at frame start, two blanked frames
    tick(20); sw_in = 3'd3; tick(12);
    chk("t1_busy", busy, 1);
    chk("t1_sel_hold", sel_out, 0);
    wait_fs();
    chk("t1_sel", sel_out, 3);
    chk("t1_clr", centroid_clr, 1);
    chk("t1_blank", blank, 1);
    tick(1);
    chk("t1_clr_1cyc", centroid_clr, 0);
    wait_fs();
    chk("t1_blank_mid", blank, 1);
    wait_fs();
    chk("t1_blank_end", blank, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_fcnt", frame_cnt, 32'(16'(rises - base)));

    // 2: three-clock glitch is rejected
    tick(10); sw_in = 3'd2; tick(3); sw_in = 3'd3;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (busy) seen = 1'b1;
    end
    chk("t2_busy", seen, 0);
    chk("t2_sel", sel_out, 3);

    // 3: invalid selection ignored, then valid selection commits
    tick(5); sw_in = 3'd5; tick(12);
    chk("t3_inval", sel_invalid, 1);
    chk("t3_busy", busy, 0);
    chk("t3_sel", sel_out, 3);
    sw_in = 3'd1; tick(12);
    chk("t3_valid", sel_invalid, 0);
    chk("t3_busy2", busy, 1);
    wait_fs();
    chk("t3_sel1", sel_out, 1);
    chk("t3_clr", centroid_clr, 1);
    wait_fs(); wait_fs();
    chk("t3_blank_end", blank, 0);

    // 4a: target retargeted while pending
    tick(5); sw_in = 3'd2; tick(12);
    chk("t4_busy", busy, 1);
    sw_in = 3'd0; tick(12);
    wait_fs();
    chk("t4_sel", sel_out, 0);
    chk("t4_clr", centroid_clr, 1);
    wait_fs(); wait_fs();
    // 4b: request withdrawn before the frame start
    tick(5); sw_in = 3'd3; tick(12);
    chk("t4b_busy", busy, 1);
    sw_in = 3'd0; tick(12);
    chk("t4b_busy_off", busy, 0);
    wait_fs();
    chk("t4b_sel", sel_out, 0);
    chk("t4b_clr", centroid_clr, 0);
    chk("t4b_blank", blank, 0);

    // 5: change during BLANK is deferred, then reset mid-BLANK
    tick(5); sw_in = 3'd2; tick(12);
    wait_fs();
    chk("t5_sel2", sel_out, 2);
    chk("t5_blank", blank, 1);
    tick(20); sw_in = 3'd1; tick(12);
    chk("t5_sel_hold", sel_out, 2);
    chk("t5_blank_hold", blank, 1);
    wait_fs();
    chk("t5_sel_mid", sel_out, 2);
    chk("t5_blank_mid", blank, 1);
    wait_fs();
    chk("t5_blank_end", blank, 0);
    chk("t5_sel_end", sel_out, 2);
    tick(1);
    chk("t5_busy_re", busy, 1);
    wait_fs();
    chk("t5_sel1", sel_out, 1);
    chk("t5_clr", centroid_clr, 1);
    chk("t5_blank2", blank, 1);
    tick(30);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", sel_out, 0);
    chk("t5_rst_blank", blank, 0);
    chk("t5_rst_clr", centroid_clr, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_fcnt", frame_cnt, 0);
    sw_in = 3'd0;
    vs_en = 1'b0;
    tick(3);
    base  = rises;
    rst_n = 1'b1;
    tick(2);

`ifdef VP_MODE_SCHED_TIMEOUT_EN
    // 6: no video; timeout commits without blanking
    sw_in = 3'd2;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_busy", seen, 1);
    tick(49);
    chk("t6_sel_hold", sel_out, 0);
    tick(1);
    chk("t6_sel", sel_out, 2);
    chk("t6_clr", centroid_clr, 1);
    chk("t6_blank", blank, 0);
    chk("t6_busy_end", busy, 0);
    chk("t6_fcnt", frame_cnt, 0);
`endif

    // Frame counter restarts from zero after reset
    vs_en = 1'b1;
    wait_fs(); wait_fs();
    chk("fcnt_after_rst", frame_cnt, 32'(16'(rises - base)));
    chk("fcnt_two", frame_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
